// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, clear FSM
// states and the natural-alignment rule.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_e;

  // Size code 2'b11 is handled as a word, so it inherits the word rule.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] byte_offset);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return byte_offset[0];
      default:  return byte_offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane steering: store lane enables and replicated store data,
// plus byte/halfword extraction with sign or zero extension for loads.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] write_data,
  input  logic [31:0] stored_word,
  output logic [3:0]  lane_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Little-endian: offset 0 is bits [7:0].
  assign sel_byte = stored_word[{byte_offset, 3'b000} +: 8];
  assign sel_half = byte_offset[1] ? stored_word[31:16] : stored_word[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    lane_en    = 4'b1111;
    store_data = write_data;
    load_data  = stored_word;
    case (mem_size)
      MEM_BYTE: begin
        lane_en    = 4'b0001 << byte_offset;
        store_data = {4{write_data[7:0]}};
        load_data  = mem_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      MEM_HALF: begin
        lane_en    = byte_offset[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data[15:0]}};
        load_data  = mem_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable MEM-stage data memory: combinational loads, edge-committed
// lane-masked stores, range/alignment flags and a post-reset clear sequencer.
module data_memory_bytelane
  import mem_pkg::*;
#(
  parameter int          DEPTH          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        ready
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic [31:0]      mem [DEPTH];
  mem_state_e       state, state_d;
  logic [IDX_W-1:0] clear_idx;
  logic             ready_q;

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             access, mis_raw, oor_raw, access_ok, store_ok;
  logic [3:0]       lane_en;
  logic [31:0]      store_data, load_data;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign offset   = address - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign oor_raw  = offset >= SPAN;
  assign mis_raw  = is_misaligned(mem_size, address[1:0]);
  assign access   = MemRead | MemWrite;

  assign access_ok = ready_q & ~mis_raw & ~oor_raw;
  assign store_ok  = access_ok & MemWrite;

  assign ready        = ready_q;
  assign misaligned   = ready_q & access & mis_raw;
  assign out_of_range = ready_q & access & oor_raw;
  assign read_data    = (access_ok && MemRead) ? load_data : 32'h0;

  mem_byte_lane u_lane (
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .byte_offset  (address[1:0]),
    .write_data   (write_data),
    .stored_word  (mem[word_idx]),
    .lane_en      (lane_en),
    .store_data   (store_data),
    .load_data    (load_data)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_CLEAR: if (clear_idx == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ready is registered so it stays low during reset even when no clear runs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clear_idx <= '0;
      ready_q   <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == ST_IDLE);
      if (state == ST_CLEAR) clear_idx <= clear_idx + 1'b1;
    end
  end

  // NOTE: the array has no reset branch; it maps onto plain RAM and is zeroed
  // by the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clear_idx] <= '0;
      end else if (store_ok) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (lane_en[lane]) mem[word_idx][8*lane +: 8] <= store_data[8*lane +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised, byte-addressable data memory for the MIPS pipeline MEM stage, succeeding the word-only data memory. Supports byte, halfword and word loads and stores (sb/sh/sw, lb/lbu/lh/lhu/lw) with sign or zero extension. Flags misaligned and out-of-range accesses. Clears itself through a reset-driven sequencer before it accepts traffic.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h00000000: byte address of word 0; must be `DEPTH*4`-aligned.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset; 0 = contents untouched, ready right after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request this cycle.
- `MemWrite`  in  1  store request this cycle.
- `mem_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `mem_unsigned`  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- `address`  in  32  byte address.
- `write_data`  in  32  store data; byte uses [7:0], halfword uses [15:0].
- `read_data`  out  32  extended load result.
- `misaligned`  out  1  access violates natural alignment.
- `out_of_range`  out  1  address outside `[BASE_ADDR, BASE_ADDR+DEPTH*4)`.
- `ready`  out  1  memory accepts accesses.

## Operation
- Byte order is little-endian: byte offset 0 is bits [7:0] of the word.
- `offset = address - BASE_ADDR` (32-bit wrap).
- `out_of_range = offset >= DEPTH*4`. This also covers any `address < BASE_ADDR`, because the subtraction wraps.
- Word index = `offset[log2(DEPTH)+1:2]`.
- Misaligned conditions:
  - halfword with `address[0]=1`;
  - word with `address[1:0]!=0`.
- Flags are evaluated only when `MemRead|MemWrite`; otherwise both are 0.
- All of `misaligned`, `out_of_range` and `read_data` are forced to 0 while `ready=0`.
- Store writes only the addressed lanes: byte → 1 lane, halfword → lanes {1,0} or {3,2}, word → all 4. Other lanes keep their value.
- A store commits only if `ready && MemWrite && !misaligned && !out_of_range`.
- Load: the addressed byte or halfword is extracted, then extended to 32 bits per `mem_unsigned`. Word loads ignore `mem_unsigned`.
- `read_data` is 0 unless `MemRead && ready && !misaligned && !out_of_range`.
- FSM states:
  - **CLEAR**: zero `mem[clear_idx]` each cycle and increment `clear_idx`. At `clear_idx == DEPTH-1`, go to IDLE next edge. External writes are ignored.
  - **IDLE**: `ready=1`; normal access.
- `reset=1` (any state, including mid-clear) on a rising edge:
  - `CLEAR_ON_RESET=1`: state ← CLEAR, `clear_idx` ← 0, no array write that edge.
  - `CLEAR_ON_RESET=0`: state ← IDLE.

## Timing
- Read is combinational from the array and address: zero-cycle load latency, valid in the same cycle as the request.
- Write is committed at the rising edge. A load in the following cycle returns the new data.
- Same-cycle load and store to the same word: `read_data` shows the pre-store value; the new value is visible after the edge.
- Reset values: `ready=0`, `read_data=0`, `misaligned=0`, `out_of_range=0`, `clear_idx=0`.
- With clear enabled, `ready` rises after exactly `DEPTH` rising edges with `reset=0`. Word k is zeroed on edge k+1 after reset falls.
- With clear disabled, `ready=1` on the first edge after reset falls.
- During CLEAR, `MemWrite` has no effect and is not queued.

## Structure
- Shared package `mem_pkg`:
  - `MEM_BYTE=2'b00`, `MEM_HALF=2'b01`, `MEM_WORD=2'b10`;
  - FSM state encoding `ST_CLEAR`, `ST_IDLE`.
- One sub-module, `mem_byte_lane`, purely combinational:
  - inputs `mem_size`, `mem_unsigned`, `address[1:0]`, `write_data`, stored word;
  - outputs 4-bit lane enable, lane-replicated store data, extended load data.
- The top module holds the array, the clear FSM, the range/alignment checks and the output gating.

## Test plan
- Reset with `DEPTH=16`, `CLEAR_ON_RESET=1`:
  - `ready=0` for exactly 16 post-reset edges, then 1;
  - a `MemWrite` to 0x4 of 0xDEADBEEF during CLEAR is lost, and a subsequent lw 0x4 returns 0.
- Byte/half stores, all following `sw 0x8 ← 0x11223344`:
  - `sb 0x9 ← 0xAA`: lw 0x8 returns 0x1122AA44;
  - `sh 0xA ← 0xBEEF`: lw 0x8 returns 0xBEEF3344.
- Loads after `sw 0xC ← 0x80FF7F01`:
  - lb 0xE (signed) → 0xFFFFFFFF; lb 0xD (signed) → 0x0000007F; lbu 0xF → 0x00000080;
  - lh 0xE (signed) → 0xFFFF80FF; lhu 0xE → 0x000080FF.
- Faults:
  - `sw 0x6` → `misaligned=1`, memory unchanged;
  - `lh 0x3` → `misaligned=1`, `read_data=0`;
  - lw 0x40 with `DEPTH=16` → `out_of_range=1`;
  - `BASE_ADDR=0x100`, lw 0xFC → `out_of_range=1`.
- Simultaneous access: in the same cycle, sw 0x10 ← 0x5 and lw 0x10 (old value 0x0):
  - `read_data=0` that cycle;
  - `read_data=0x5` the next cycle.
- Reset mid-clear: assert reset at clear cycle 7 for one cycle → `ready` rises 16 edges after that reset falls; all words read 0.
